// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master native memory bus arbiter:
// state encodings, one-hot grant codes, default error word and the round-robin pick.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic [1:0]  GNT_NONE = 2'b00;
  localparam logic [1:0]  GNT_M0   = 2'b01;
  localparam logic [1:0]  GNT_M1   = 2'b10;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // rr_last = 1 means m1 owned the bus most recently, so m0 wins a tie.
  function automatic logic [1:0] rr_pick(input logic m0_req, input logic m1_req,
                                         input logic rr_last);
    logic [1:0] gnt;
    gnt = GNT_NONE;
    if (m0_req && m1_req) gnt = rr_last ? GNT_M0 : GNT_M1;
    else if (m0_req)      gnt = GNT_M0;
    else if (m1_req)      gnt = GNT_M1;
    return gnt;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// picorv32-style native memory bus: valid/ready handshake with addr, wdata, wstrb and rdata.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic [31:0]       rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mem_arbiter_bus_timeout.sv
// Counts BUSY cycles without a slave response; expired marks the last cycle the slave may still answer.
module mem_arbiter_bus_timeout #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Holding at the terminal count keeps the flag stable if the owner is slow to leave BUSY.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                 cnt_d = '0;
    else if (enable && !expired) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one decoded memory port between the CPU (m0) and a second master (m1),
// one transaction per grant, with a bus timeout that completes hung accesses with an error word.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  m0,
  mem_arbiter_if.slave  m1,
  mem_arbiter_if.master s,
  output logic [1:0]    grant,
  output logic          timeout_err
);

  arb_state_e  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_last_q, rr_last_d;
  logic        timeout_err_q, timeout_err_d;

  logic        busy, own0, own1, own_valid, hit, forced, expired;
  logic [ADDR_W-1:0] addr_mux;
  logic [31:0] wdata_mux;
  logic [3:0]  wstrb_mux;

  assign busy      = (state_q == ST_BUSY);
  assign own0      = busy & grant_q[0];
  assign own1      = busy & grant_q[1];
  assign own_valid = (own0 & m0.valid) | (own1 & m1.valid);
  // A slave response in the expiry cycle still counts as a normal completion.
  assign hit       = own_valid & s.ready;
  assign forced    = own_valid & ~s.ready & expired;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    wstrb_mux = '0;
    if (own0) begin
      addr_mux  = m0.addr;
      wdata_mux = m0.wdata;
      wstrb_mux = m0.wstrb;
    end else if (own1) begin
      addr_mux  = m1.addr;
      wdata_mux = m1.wdata;
      wstrb_mux = m1.wstrb;
    end
  end

  assign s.valid  = own_valid & ~forced;
  assign s.addr   = addr_mux;
  assign s.wdata  = wdata_mux;
  assign s.wstrb  = forced ? 4'b0000 : wstrb_mux;

  assign m0.ready = own0 & (hit | forced);
  assign m1.ready = own1 & (hit | forced);
  assign m0.rdata = (own0 & forced) ? ERR_DATA : s.rdata;
  assign m1.rdata = (own1 & forced) ? ERR_DATA : s.rdata;

  mem_arbiter_bus_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_bus_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (~busy),
    .enable  (busy),
    .expired (expired)
  );

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_last_d     = rr_last_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0.valid || m1.valid) begin
          grant_d = rr_pick(m0.valid, m1.valid, rr_last_q);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (hit || forced) begin
          rr_last_d     = grant_q[1];
          timeout_err_d = forced;
          grant_d       = GNT_NONE;
          state_d       = ST_DONE;
        end else if (!own_valid) begin
          // Owner withdrew its request: release without completing, fairness untouched.
          grant_d = GNT_NONE;
          state_d = ST_IDLE;
        end
      end
      // One dead cycle lets the slave-side ready pipeline clear before the next request.
      ST_DONE: state_d = ST_IDLE;
      default: begin
        grant_d = GNT_NONE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= GNT_NONE;
      rr_last_q     <= 1'b1;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      rr_last_q     <= rr_last_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random two-master traffic, checked every cycle
// against a transaction-level model of ownership, round-robin order and timeout rules.
module tb_mem_arbiter;
  localparam int          TIMEOUT = 256;
  localparam logic [31:0] ERRW    = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32)) m0_if ();
  mem_arbiter_if #(.ADDR_W(32)) m1_if ();
  mem_arbiter_if #(.ADDR_W(32)) s_if ();
  logic [1:0] grant;
  logic       timeout_err;

  mem_arbiter #(.ADDR_W(32), .TIMEOUT(TIMEOUT), .ERR_DATA(ERRW)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
    .grant(grant), .timeout_err(timeout_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  // master stimulus
  logic        mv[2];
  logic [31:0] ma[2], md[2];
  logic [3:0]  ms[2];
  bit          got[2];
  logic [31:0] last_rd[2];
  int          issued[2], done[2], ab[2];

  // reference model: who holds the bus, how long it has waited, who was served last
  int ph;       // 0 free, 1 transaction in progress, 2 turnaround gap
  int own, last, bcnt, lat, lat_fix;
  bit to_prev, rand_lat, spur_en;
  int gq[$];    // owners in order of grant

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    ph = 0; last = 1; to_prev = 1'b0; bcnt = 0;
  endtask

  task automatic apply();
    m0_if.valid = mv[0]; m0_if.addr = ma[0]; m0_if.wdata = md[0]; m0_if.wstrb = ms[0];
    m1_if.valid = mv[1]; m1_if.addr = ma[1]; m1_if.wdata = md[1]; m1_if.wstrb = ms[1];
  endtask

  // One clock cycle: drive, check outputs against the model, advance the model, cross the edge.
  task automatic step();
    logic [1:0] eg; logic ev, ownv, hit, tmo; logic er[2];
    logic [31:0] ea, ed; logic [3:0] es;
    apply();
    if (rst) model_reset();
    s_if.ready = (ph == 1 && bcnt == lat) || (spur_en && ph != 1 && $urandom_range(0, 3) == 0);
    s_if.rdata = $urandom;
    #2;
    eg = 2'b00; ev = 1'b0; ea = '0; ed = '0; es = '0; ownv = 1'b0; hit = 1'b0; tmo = 1'b0;
    er[0] = 1'b0; er[1] = 1'b0;
    if (ph == 1) begin
      ownv = mv[own];
      hit  = ownv && s_if.ready;
      tmo  = ownv && !s_if.ready && bcnt == TIMEOUT - 1;
      eg   = (own == 1) ? 2'b10 : 2'b01;
      ev   = ownv && !tmo;
      ea   = ma[own];
      ed   = md[own];
      es   = tmo ? 4'b0000 : ms[own];
      er[own] = hit || tmo;
    end
    chk("grant", grant, eg);
    chk("s_valid", s_if.valid, ev);
    chk("s_addr", s_if.addr, ea);
    chk("s_wdata", s_if.wdata, ed);
    chk("s_wstrb", s_if.wstrb, es);
    chk("m0_ready", m0_if.ready, er[0]);
    chk("m1_ready", m1_if.ready, er[1]);
    chk("timeout_err", timeout_err, to_prev);
    got[0] = er[0]; got[1] = er[1];
    if (er[0]) begin chk("m0_rdata", m0_if.rdata, tmo ? ERRW : s_if.rdata); last_rd[0] = m0_if.rdata; done[0]++; end
    if (er[1]) begin chk("m1_rdata", m1_if.rdata, tmo ? ERRW : s_if.rdata); last_rd[1] = m1_if.rdata; done[1]++; end
    if (!rst) begin
      to_prev = tmo;
      case (ph)
        0: if (mv[0] || mv[1]) begin
             own = (mv[0] && mv[1]) ? ((last == 1) ? 0 : 1) : (mv[0] ? 0 : 1);
             gq.push_back(own);
             lat = rand_lat ? int'($urandom_range(1, 3)) : lat_fix;
             bcnt = 0; ph = 1;
           end
        1: if (hit || tmo) begin last = own; ph = 2; end
           else if (!ownv) ph = 0;
           else bcnt++;
        default: ph = 0;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic serve(input int maxc, input string tag, output int n);
    n = 0;
    do begin step(); n++; end while (!(got[0] || got[1]) && n < maxc);
    chk({tag, "_completed"}, got[0] | got[1], 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1; mv[0] = 1'b0; mv[1] = 1'b0;
    step(); step();
    rst = 1'b0; gq.delete();
  endtask

  task automatic new_req(input int i);
    mv[i] = 1'b1; ma[i] = $urandom & 32'h0000_FFFC; md[i] = $urandom;
    ms[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
    issued[i]++;
  endtask

  initial begin
    int n;
    bit draining;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = '0; md[i] = '0; ms[i] = '0; got[i] = 1'b0;
      issued[i] = 0; done[i] = 0; ab[i] = 0; last_rd[i] = '0;
    end
    s_if.ready = 1'b0; s_if.rdata = '0;
    rand_lat = 1'b0; spur_en = 1'b0; lat_fix = 1; own = 0; lat = 1;
    model_reset();
    apply();
    @(posedge clk); #1;
    do_reset();

    // single m0 read, slave answers one cycle after s_valid
    ma[0] = 32'h0000_0100; md[0] = '0; ms[0] = 4'b0000; mv[0] = 1'b1;
    serve(10, "t1", n);
    chk("t1_cycles", n, 3);
    chk("t1_owner", gq[0], 0);
    mv[0] = 1'b0; step(); step();

    // simultaneous requests after reset, both held: 01, 10, 01
    do_reset();
    ma[0] = 32'h0000_0200; ma[1] = 32'h0000_0300; mv[0] = 1'b1; mv[1] = 1'b1;
    for (int k = 0; k < 3; k++) serve(10, "t2", n);
    chk("t2_first", gq[0], 0);
    chk("t2_second", gq[1], 1);
    chk("t2_third", gq[2], 0);
    mv[0] = 1'b0; mv[1] = 1'b0; step(); step();

    // m1 byte write: strobes and address visible only while the transaction is live
    ma[1] = 32'h0000_3000; md[1] = 32'h0000_005A; ms[1] = 4'b0001; mv[1] = 1'b1;
    serve(10, "t3", n);
    mv[1] = 1'b0; apply(); #2;
    chk("t3_gap_addr", s_if.addr, 32'h0);
    chk("t3_gap_wstrb", s_if.wstrb, 4'b0000);
    step(); step();

    // unmapped read: forced completion on the 256th waiting cycle
    lat_fix = -1;
    ma[0] = 32'h0000_5000; ms[0] = 4'b0000; mv[0] = 1'b1;
    serve(TIMEOUT + 20, "t4", n);
    chk("t4_cycles", n, TIMEOUT + 1);
    chk("t4_rdata", last_rd[0], ERRW);
    mv[0] = 1'b0; apply(); #2;
    chk("t4_err_pulse", timeout_err, 1'b1);
    step(); step();

    // slave answers exactly in the expiry cycle: real data, no error
    lat_fix = TIMEOUT - 1;
    mv[0] = 1'b1;
    serve(TIMEOUT + 20, "t5", n);
    chk("t5_cycles", n, TIMEOUT + 1);
    mv[0] = 1'b0; apply(); #2;
    chk("t5_no_err", timeout_err, 1'b0);
    step(); step();

    // asynchronous reset in the middle of an m0 transaction with m1 waiting
    do_reset();
    lat_fix = 3;
    ma[0] = 32'h0000_0400; mv[0] = 1'b1;
    step();
    ma[1] = 32'h0000_0800; mv[1] = 1'b1;
    step();
    apply(); s_if.ready = 1'b1; #2;
    chk("t6_ready_before", m0_if.ready, 1'b1);
    rst = 1'b1; #1;
    chk("t6_s_valid", s_if.valid, 1'b0);
    chk("t6_m0_ready", m0_if.ready, 1'b0);
    chk("t6_m1_ready", m1_if.ready, 1'b0);
    chk("t6_grant", grant, 2'b00);
    mv[0] = 1'b0; apply(); s_if.ready = 1'b0; model_reset();
    @(posedge clk); #1;
    rst = 1'b0; gq.delete();
    step();
    chk("t6_owner_after", gq[0], 1);
    serve(10, "t6", n);
    mv[1] = 1'b0; step(); step();

    // random traffic with abandons and stray s_ready, then drain
    rand_lat = 1'b1; spur_en = 1'b1; draining = 1'b0;
    for (int i = 0; i < 2; i++) begin issued[i] = 0; done[i] = 0; ab[i] = 0; end
    for (int c = 0; c < 700; c++) begin
      if (c >= 600) draining = 1'b1;
      if (draining && !mv[0] && !mv[1]) break;
      for (int i = 0; i < 2; i++) begin
        if (mv[i]) begin
          if (got[i]) begin
            if (!draining && $urandom_range(0, 1) == 1) new_req(i);
            else mv[i] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            mv[i] = 1'b0; ab[i]++;
          end
        end else if (!draining && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
      step();
    end
    chk("rand_drained", {30'd0, mv[1], mv[0]}, 32'd0);
    chk("rand_m0_accounted", issued[0], done[0] + ab[0]);
    chk("rand_m1_accounted", issued[1], done[1] + ab[1]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
